instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/HALT sequencer feeding a one-entry output buffer.
// Optional feature macro FETCH_ILLEGAL_HALT_EN: halt instead of loading an opcode 6'b111111 word.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halt,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] FETCH_LIMIT = 32'(MEM_WORDS * 4);

  state_t      state_r;
  logic [31:0] pc_r;
  logic        can_load_s;
  logic        in_range_s;
  logic        transfer_s;
  logic        illegal_s;

  assign can_load_s = !out_valid || out_ready;
  assign in_range_s = (pc_r < FETCH_LIMIT);
  assign transfer_s = out_valid && out_ready;

`ifdef FETCH_ILLEGAL_HALT_EN
  assign illegal_s = (imem_rdata[31:26] == 6'b111111);
`else
  assign illegal_s = 1'b0;
`endif

  // Memory address: RESET_PC while idle (including reset), otherwise the live pc.
  always_comb begin
    imem_addr = RESET_PC;
    if (state_r == IDLE) begin
      imem_addr = RESET_PC;
    end else begin
      imem_addr = pc_r;
    end
  end

  // Control FSM, pc and output buffer; redirect outranks load and stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= 32'h0000_0000;
      out_pc       <= 32'h0000_0000;
      out_pc_plus4 <= 32'h0000_0004;
      halt         <= 1'b0;
      fetch_count  <= 16'h0000;
    end else begin
      if (transfer_s) begin
        fetch_count <= fetch_count + 16'd1;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            pc_r      <= {redirect_pc[31:2], 2'b00};
            out_valid <= 1'b0;
          end else if (can_load_s) begin
            if (!in_range_s || illegal_s) begin
              // pc is left on the offending address for debug visibility.
              state_r   <= HALT;
              out_valid <= 1'b0;
              halt      <= 1'b1;
            end else begin
              out_instr    <= imem_rdata;
              out_pc       <= pc_r;
              out_pc_plus4 <= pc_r + 32'd4;
              out_valid    <= 1'b1;
              pc_r         <= pc_r + 32'd4;
            end
          end
        end
        HALT: begin
          if (start) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            halt    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          halt      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl; memory holds 32'h1000_0000+i, word 16 is 32'hFC20_1800.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        halt;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:19];

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_WORDS(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .halt(halt), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    imem_rdata = 32'h0000_0000;
    if (imem_addr < 32'd80) imem_rdata = mem[imem_addr[6:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[16] = 32'hFC20_1800;

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pc4", out_pc_plus4, 32'd4);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_cnt", 32'(fetch_count), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    rst_n = 1'b1;

    // IDLE holds without start, even under redirect
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_addr", imem_addr, 32'd0);
    redirect_valid = 1'b0;

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_valid", 32'(out_valid), 32'd0);
    step();
    chk("f0_valid", 32'(out_valid), 32'd1);
    chk("f0_pc", out_pc, 32'd0);
    chk("f0_instr", out_instr, 32'h1000_0000);
    chk("f0_cnt", 32'(fetch_count), 32'd0);
    step();
    chk("f4_pc", out_pc, 32'd4);
    chk("f4_cnt", 32'(fetch_count), 32'd1);
    step();
    chk("f8_pc", out_pc, 32'd8);
    chk("f8_cnt", 32'(fetch_count), 32'd2);

    // stall for three cycles at out_pc=8
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", out_pc, 32'd8);
      chk("stall_instr", out_instr, 32'h1000_0002);
      chk("stall_cnt", 32'(fetch_count), 32'd2);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("rel_pc", out_pc, 32'd12);
    chk("rel_instr", out_instr, 32'h1000_0003);
    chk("rel_cnt", 32'(fetch_count), 32'd3);

    for (int k = 4; k <= 12; k++) step();
    chk("pre_redir_pc", out_pc, 32'd48);
    chk("pre_redir_cnt", 32'(fetch_count), 32'd12);

    redirect_valid = 1'b1; redirect_pc = 32'h0000_004E;
    step();
    redirect_valid = 1'b0;
    chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("bubble_cnt", 32'(fetch_count), 32'd13);
    step();
    chk("tgt_valid", 32'(out_valid), 32'd1);
    chk("tgt_pc", out_pc, 32'h4C);
    chk("tgt_pc4", out_pc_plus4, 32'h50);
    chk("tgt_instr", out_instr, 32'h1000_0013);
    step();
    chk("end_halt", 32'(halt), 32'd1);
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_addr", imem_addr, 32'd80);
    chk("end_cnt", 32'(fetch_count), 32'd14);

    // redirect ignored in HALT
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("halt_redir", 32'(halt), 32'd1);
    chk("halt_addr", imem_addr, 32'd80);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_halt", 32'(halt), 32'd0);
    chk("restart_valid", 32'(out_valid), 32'd0);
    step();
    chk("restart_pc", out_pc, 32'd0);
    chk("restart_valid1", 32'(out_valid), 32'd1);

    // run towards the end; start pulse inside FETCH must be ignored
    for (int k = 1; k <= 15; k++) begin
      start = (k == 5);
      step();
      chk("run_pc", out_pc, 32'(4 * k));
      chk("run_cnt", 32'(fetch_count), 32'(14 + k));
    end
    start = 1'b0;
    step();
`ifdef FETCH_ILLEGAL_HALT_EN
    chk("ill_halt", 32'(halt), 32'd1);
    chk("ill_valid", 32'(out_valid), 32'd0);
    chk("ill_addr", imem_addr, 32'd64);
    chk("ill_cnt", 32'(fetch_count), 32'd30);
    step();
    chk("ill_cnt2", 32'(fetch_count), 32'd30);
`else
    chk("w64_pc", out_pc, 32'd64);
    chk("w64_instr", out_instr, 32'hFC20_1800);
    chk("w64_valid", 32'(out_valid), 32'd1);
    for (int k = 17; k <= 19; k++) step();
    chk("last_pc", out_pc, 32'd76);
    chk("last_cnt", 32'(fetch_count), 32'd33);
    step();
    chk("end2_halt", 32'(halt), 32'd1);
    chk("end2_valid", 32'(out_valid), 32'd0);
    chk("end2_cnt", 32'(fetch_count), 32'd34);
`endif

    // reset asserted mid-stall clears outputs without a clock edge
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_halt", 32'(halt), 32'd0);
    chk("arst_cnt", 32'(fetch_count), 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_addr", imem_addr, 32'd0);
    step();
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
